// File: rtl/crossing_gate_sequencer.sv
// Level-crossing barrier sequencer: warn, lower, hold closed, then raise after a clear interval.
// Optional INPUT_SYNC_EN adds 2-flop synchronizers on occ_x, occ_y, lim_down and lim_up.
module crossing_gate_sequencer #(
  parameter int WARN_CYCLES  = 8,
  parameter int MOVE_TIMEOUT = 32,
  parameter int CLEAR_HOLD   = 4,
  parameter int CNT_W        = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic occ_x,
  input  logic occ_y,
  input  logic lim_down,
  input  logic lim_up,
  output logic motor_down,
  output logic motor_up,
  output logic lamp,
  output logic gate_closed,
  output logic fault,
  output logic busy
);

  typedef enum logic [2:0] {
    S_OPEN   = 3'd0,
    S_WARN   = 3'd1,
    S_LOWER  = 3'd2,
    S_CLOSED = 3'd3,
    S_HOLD   = 3'd4,
    S_RAISE  = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] WARN_LAST  = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST  = CNT_W'(MOVE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_HOLD - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic [3:0] raw_in;
  logic [3:0] in_s;
  logic       occ;
  logic       lim_down_s;
  logic       lim_up_s;

  assign raw_in = {lim_up, lim_down, occ_y, occ_x};

`ifdef INPUT_SYNC_EN
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end
      assign in_s[gi] = sync_reg;
    end
  endgenerate
`else
  assign in_s = raw_in;
`endif

  assign occ        = in_s[0] | in_s[1];
  assign lim_down_s = in_s[2];
  assign lim_up_s   = in_s[3];

  // Timer restarts on every state change; saturates so long CLOSED stays never wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_OPEN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg != {CNT_W{1'b1}}) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg != S_OPEN && lim_down_s && lim_up_s) begin
      state_next = S_FAULT;
    end else begin
      case (state_reg)
        S_OPEN:   if (occ) state_next = S_WARN;
        S_WARN:   if (cnt_reg == WARN_LAST) state_next = S_LOWER;
        S_LOWER: begin
          if (lim_down_s)                  state_next = S_CLOSED;
          else if (cnt_reg == MOVE_LAST)   state_next = S_FAULT;
        end
        S_CLOSED: if (!occ) state_next = S_HOLD;
        S_HOLD: begin
          if (occ)                         state_next = S_CLOSED;
          else if (cnt_reg == CLEAR_LAST)  state_next = S_RAISE;
        end
        // Re-occupation during raising re-lowers straight away, ahead of lim_up.
        S_RAISE: begin
          if (occ)                         state_next = S_LOWER;
          else if (lim_up_s)               state_next = S_OPEN;
          else if (cnt_reg == MOVE_LAST)   state_next = S_FAULT;
        end
        S_FAULT:  state_next = S_FAULT;
        default:  state_next = S_FAULT;
      endcase
    end
  end

  always_comb begin
    motor_down  = 1'b0;
    motor_up    = 1'b0;
    lamp        = 1'b0;
    gate_closed = 1'b0;
    fault       = 1'b0;
    busy        = (state_reg != S_OPEN);
    case (state_reg)
      S_OPEN:   ;
      S_WARN:   lamp = 1'b1;
      S_LOWER: begin
        lamp       = 1'b1;
        motor_down = 1'b1;
      end
      S_CLOSED, S_HOLD: begin
        lamp        = 1'b1;
        gate_closed = 1'b1;
      end
      S_RAISE: begin
        lamp     = 1'b1;
        motor_up = 1'b1;
      end
      S_FAULT: begin
        lamp  = 1'b1;
        fault = 1'b1;
      end
      default: begin
        lamp  = 1'b1;
        fault = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_crossing_gate_sequencer.sv
// Scoreboard bench for crossing_gate_sequencer: each step queues stimulus and the expected
// output vector {busy,fault,gate_closed,lamp,motor_up,motor_down}, popped after the edge.
module tb_crossing_gate_sequencer;

`ifdef INPUT_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  localparam logic [5:0] O_OPEN   = 6'b000000;
  localparam logic [5:0] O_WARN   = 6'b100100;
  localparam logic [5:0] O_LOWER  = 6'b100101;
  localparam logic [5:0] O_CLOSED = 6'b101100;
  localparam logic [5:0] O_RAISE  = 6'b100110;
  localparam logic [5:0] O_FAULT  = 6'b110100;

  // Stimulus nibble: {occ_x, occ_y, lim_down, lim_up}
  localparam logic [3:0] I_NONE = 4'b0000;
  localparam logic [3:0] I_X    = 4'b1000;
  localparam logic [3:0] I_Y    = 4'b0100;
  localparam logic [3:0] I_XY   = 4'b1100;
  localparam logic [3:0] I_XD   = 4'b1010;
  localparam logic [3:0] I_YD   = 4'b0110;
  localparam logic [3:0] I_D    = 4'b0010;
  localparam logic [3:0] I_U    = 4'b0001;
  localparam logic [3:0] I_XDU  = 4'b1011;

  logic clk = 1'b0;
  logic rst;
  logic occ_x, occ_y, lim_down, lim_up;
  logic motor_down, motor_up, lamp, gate_closed, fault, busy;
  logic [5:0] outs;

  int checks   = 0;
  int failures = 0;

  logic [3:0] stim_q[$];
  logic [5:0] exp_q[$];

  assign outs = {busy, fault, gate_closed, lamp, motor_up, motor_down};

  crossing_gate_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .occ_x      (occ_x),
    .occ_y      (occ_y),
    .lim_down   (lim_down),
    .lim_up     (lim_up),
    .motor_down (motor_down),
    .motor_up   (motor_up),
    .lamp       (lamp),
    .gate_closed(gate_closed),
    .fault      (fault),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sched(input logic [3:0] s, input logic [5:0] e, input int n);
    for (int i = 0; i < n; i++) begin
      stim_q.push_back(s);
      exp_q.push_back(e);
    end
  endtask

  // Shared run-up from OPEN: 8 warn cycles, lower, then lim_down confirms closed.
  task automatic sched_close(input logic [3:0] occ_in);
    sched(occ_in, O_WARN, 8);
    sched(occ_in, O_LOWER, 4);
    sched(occ_in | I_D, O_CLOSED, 2);
  endtask

  task automatic test_reset();
    logic [5:0] e;
    int k;
    rst = 1'b1;
    {occ_x, occ_y, lim_down, lim_up} = I_NONE;
    #1;
    checks++;
    if (outs !== O_OPEN) begin
      failures++;
      $display("FAIL reset_async got=%b exp=%b", outs, O_OPEN);
    end else $display("reset_async out=%b", outs);
    tick();
    rst = 1'b0;
    sched(I_X, O_WARN, 8);
    sched(I_X, O_LOWER, 2);
    k = 0;
    while (exp_q.size() != 0) begin
      {occ_x, occ_y, lim_down, lim_up} = stim_q.pop_front();
      e = exp_q.pop_front();
      tick();
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL reset_runup step=%0d got=%b exp=%b", k, outs, e);
      end else $display("reset_runup step=%0d out=%b", k, outs);
      k++;
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_OPEN) begin
      failures++;
      $display("FAIL reset_mid_lower got=%b exp=%b", outs, O_OPEN);
    end else $display("reset_mid_lower out=%b", outs);
    {occ_x, occ_y, lim_down, lim_up} = I_NONE;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== O_OPEN) begin
      failures++;
      $display("FAIL reset_release got=%b exp=%b", outs, O_OPEN);
    end else $display("reset_release out=%b", outs);
  endtask

  task automatic test_normal();
    logic [5:0] e;
    int k;
    sched_close(I_X);
    sched(I_D, O_CLOSED, 4);
    sched(I_D, O_RAISE, 1);
    sched(I_NONE, O_RAISE, 1);
    sched(I_U, O_OPEN, 2);
    sched(I_NONE, O_OPEN, 1);
    k = 0;
    while (exp_q.size() != 0) begin
      {occ_x, occ_y, lim_down, lim_up} = stim_q.pop_front();
      e = exp_q.pop_front();
      tick();
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL normal step=%0d got=%b exp=%b", k, outs, e);
      end else $display("normal step=%0d out=%b", k, outs);
      k++;
    end
  endtask

  task automatic test_hold_reoccupy();
    logic [5:0] e;
    int k;
    sched_close(I_Y);
    sched(I_D, O_CLOSED, 2);
    sched(I_YD, O_CLOSED, 2);
    sched(I_D, O_CLOSED, 4);
    sched(I_D, O_RAISE, 1);
    sched(I_U, O_OPEN, 1);
    sched(I_NONE, O_OPEN, 1);
    k = 0;
    while (exp_q.size() != 0) begin
      {occ_x, occ_y, lim_down, lim_up} = stim_q.pop_front();
      e = exp_q.pop_front();
      tick();
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL hold_reoccupy step=%0d got=%b exp=%b", k, outs, e);
      end else $display("hold_reoccupy step=%0d out=%b", k, outs);
      k++;
    end
  endtask

  task automatic test_raise_reoccupy();
    logic [5:0] e;
    int k;
    sched_close(I_X);
    sched(I_D, O_CLOSED, 4);
    sched(I_D, O_RAISE, 1);
    sched(I_NONE, O_RAISE, 1);
    sched(I_X, O_LOWER, 2);
    sched(I_XD, O_CLOSED, 1);
    sched(I_D, O_CLOSED, 4);
    sched(I_D, O_RAISE, 1);
    sched(I_U, O_OPEN, 1);
    sched(I_NONE, O_OPEN, 1);
    k = 0;
    while (exp_q.size() != 0) begin
      {occ_x, occ_y, lim_down, lim_up} = stim_q.pop_front();
      e = exp_q.pop_front();
      tick();
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL raise_reoccupy step=%0d got=%b exp=%b", k, outs, e);
      end else $display("raise_reoccupy step=%0d out=%b", k, outs);
      k++;
    end
  endtask

  task automatic test_timeout();
    logic [5:0] e;
    int k;
    sched(I_XY, O_WARN, 8);
    sched(I_XY, O_LOWER, 32);
    sched(I_XY, O_FAULT, 1);
    sched(I_NONE, O_FAULT, 4);
    sched(I_U, O_FAULT, 1);
    k = 0;
    while (exp_q.size() != 0) begin
      {occ_x, occ_y, lim_down, lim_up} = stim_q.pop_front();
      e = exp_q.pop_front();
      tick();
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL timeout step=%0d got=%b exp=%b", k, outs, e);
      end else $display("timeout step=%0d out=%b", k, outs);
      k++;
    end
    {occ_x, occ_y, lim_down, lim_up} = I_NONE;
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== O_OPEN) begin
      failures++;
      $display("FAIL timeout_reset got=%b exp=%b", outs, O_OPEN);
    end else $display("timeout_reset out=%b", outs);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_conflict();
    logic [5:0] e;
    int k;
    sched_close(I_X);
    if (LAT > 0) sched(I_XDU, O_CLOSED, LAT);
    sched(I_XDU, O_FAULT, 1);
    sched(I_NONE, O_FAULT, 3);
    k = 0;
    while (exp_q.size() != 0) begin
      {occ_x, occ_y, lim_down, lim_up} = stim_q.pop_front();
      e = exp_q.pop_front();
      tick();
      checks++;
      if (outs !== e) begin
        failures++;
        $display("FAIL conflict step=%0d got=%b exp=%b", k, outs, e);
      end else $display("conflict step=%0d out=%b", k, outs);
      k++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (outs !== O_OPEN) begin
      failures++;
      $display("FAIL conflict_reset got=%b exp=%b", outs, O_OPEN);
    end else $display("conflict_reset out=%b", outs);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_normal();
    test_hold_reoccupy();
    test_raise_reoccupy();
    test_timeout();
    test_conflict();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/crossing_gate_sequencer.md
Name: crossing_gate_sequencer

Overview:
Sequential barrier controller for one level crossing. Consumes the per-track occupancy requests from the track-sensor OR stage (occ_x, occ_y) and drives the barrier motor, warning lamp and status outputs. Closes the barrier through a fixed warning/lowering handshake with the limit switches, and raises it only after a guaranteed clear interval. Sits between the sensor combiner and the motor/lamp driver board.

Parameters:
WARN_CYCLES, 8, lamp-only cycles before lowering starts (>=1)
MOVE_TIMEOUT, 32, max cycles in LOWER/RAISE awaiting the limit switch before FAULT (>=2)
CLEAR_HOLD, 4, consecutive clear cycles required before raising (>=1)
CNT_W, 8, state-timer width; must hold max(WARN_CYCLES, MOVE_TIMEOUT, CLEAR_HOLD)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
occ_x  in  1  track X occupied (Gx from sensor stage)
occ_y  in  1  track Y occupied (Gy from sensor stage)
lim_down  in  1  barrier fully-down limit switch
lim_up  in  1  barrier fully-up limit switch
motor_down  out  1  drive barrier down
motor_up  out  1  drive barrier up
lamp  out  1  warning lamp
gate_closed  out  1  barrier confirmed down
fault  out  1  sequencer locked in FAULT
busy  out  1  high in every state except OPEN

Behaviour:
- One clock; reset is asynchronous and active-high. rst forces OPEN and clears the timer immediately, from any state, including mid-motion or FAULT.
- Reset values: all outputs 0.
- occ = occ_x | occ_y, sampled on the rising clk edge.
- Moore outputs, decoded from the state register only; no combinational input-to-output path. An input sampled at edge N is first visible on outputs after edge N.
- Timer cnt is cleared on every state entry and increments each cycle while in the state.
- States and per-state outputs:
  - OPEN: all outputs 0.
  - WARN: lamp=1.
  - LOWER: lamp=1, motor_down=1.
  - CLOSED: lamp=1, gate_closed=1.
  - HOLD: lamp=1, gate_closed=1.
  - RAISE: lamp=1, motor_up=1.
  - FAULT: lamp=1, fault=1, both motor outputs 0.
- busy=1 in every state except OPEN.
- Transitions:
  - OPEN -> WARN when occ=1.
  - WARN -> LOWER when cnt==WARN_CYCLES-1, so lamp-only time is exactly WARN_CYCLES cycles. occ dropping in WARN does not abort.
  - LOWER -> CLOSED when lim_down=1. LOWER -> FAULT when cnt==MOVE_TIMEOUT-1 and lim_down=0. lim_down wins if both occur in the same cycle.
  - CLOSED -> HOLD when occ=0.
  - HOLD -> CLOSED when occ=1; the clear count restarts on the next HOLD entry. HOLD -> RAISE when cnt==CLEAR_HOLD-1 and occ=0.
  - RAISE -> OPEN when lim_up=1. RAISE -> LOWER when occ=1, which re-lowers immediately with no re-warn; occ has priority over lim_up. RAISE -> FAULT on timeout, same rule as LOWER.
  - FAULT is left only by rst.
- Simultaneous lim_down=1 and lim_up=1 in any state other than OPEN -> FAULT next cycle. This check has priority over all other transitions.
- occ_x and occ_y are treated identically. Both asserted is the same as one asserted.
- motor_down and motor_up are never both 1.

Optional Feature:
INPUT_SYNC_EN
- Defined: occ_x, occ_y, lim_down and lim_up each pass through a 2-flop synchronizer, reset to 0, before use. This adds exactly 2 cycles of input-to-transition latency.
- Undefined: inputs are used directly, and the design is for synchronous sources only.
- All timer counts are unchanged in both builds.

Test Plan:
1. Reset mid-LOWER: assert rst while motor_down=1 -> all outputs 0 immediately (async); state OPEN after release.
2. Normal close/open, defaults: occ_x=1 at cycle 0.
   - Cycles 1-8: lamp=1 only.
   - Cycle 9: motor_down=1.
   - lim_down=1 at cycle 12 -> gate_closed=1 from cycle 13.
   - Drop occ_x -> motor_up=1 exactly 4 cycles after the first clear sample.
   - lim_up=1 -> all outputs 0 next cycle.
3. Re-occupy in HOLD: from CLOSED, occ=0 for 2 cycles then occ_y=1 -> gate_closed stays 1, motor_up never asserts; a subsequent clear needs 4 full cycles.
4. Re-occupy during RAISE: occ_x=1 while motor_up=1 -> motor_down=1 next cycle with no WARN phase; lim_down then -> gate_closed=1.
5. Lower timeout: occ_x=1, lim_down held 0 -> fault=1 after 32 cycles in LOWER, motors 0, lamp=1; fault persists with occ removed until rst.
6. Limit conflict: in CLOSED drive lim_down=1 and lim_up=1 -> fault=1 next cycle. Repeat with INPUT_SYNC_EN defined -> fault=1 three cycles after the conflict.
